// File: rtl/regfile_writeback_arbiter.sv
// Write-side front end of the 32x32 register file: arbitrates ALU and buffered load
// results onto the single write port and tracks registers with loads in flight.
module regfile_writeback_arbiter #(
  parameter int FIFO_DEPTH  = 4,
  parameter int DRAIN_LEVEL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        issue_mark,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  query_rs1,
  input  logic [4:0]  query_rs2,
  output logic        busy_rs1,
  output logic        busy_rs2,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        write_enable
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {NORMAL, DRAIN} state_t;

  state_t         state, state_next;
  logic [4:0]     fifo_rd   [FIFO_DEPTH];
  logic [31:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_next;
  logic [31:0]    busy, busy_next;
  logic           alu_acc, push, pop, win_valid;
  logic [4:0]     win_rd, head_rd;
  logic [31:0]    win_data;

  assign head_rd   = fifo_rd[rd_ptr];
  assign mem_ready = (count != CW'(FIFO_DEPTH));
  assign busy_rs1  = busy[query_rs1];
  assign busy_rs2  = busy[query_rs2];

  always_comb begin
    alu_ready  = (state == NORMAL);
    alu_acc    = alu_valid & alu_ready;
    push       = mem_valid & mem_ready;
    // In NORMAL the ALU owns the slot; the FIFO head only fills idle cycles.
    pop        = (count != '0) && ((state == DRAIN) || !alu_acc);
    count_next = count + CW'(push) - CW'(pop);
    win_valid  = alu_acc | pop;
    win_rd     = alu_acc ? alu_rd   : head_rd;
    win_data   = alu_acc ? alu_data : fifo_data[rd_ptr];
    state_next = state;
    case (state)
      NORMAL: if (count_next == CW'(FIFO_DEPTH)) state_next = DRAIN;
      DRAIN:  if (count_next <= CW'(DRAIN_LEVEL)) state_next = NORMAL;
      default: state_next = NORMAL;
    endcase
    busy_next = busy;
    if (pop && head_rd != 5'd0) busy_next[head_rd] = 1'b0;
    if (issue_mark && issue_rd != 5'd0) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= NORMAL;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      busy         <= '0;
      write_enable <= 1'b0;
      write_reg    <= 5'd0;
      write_data   <= 32'd0;
    end else begin
      state        <= state_next;
      count        <= count_next;
      busy         <= busy_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      // rd==0 results are consumed but never reach the file.
      write_enable <= win_valid && (win_rd != 5'd0);
      if (win_valid && win_rd != 5'd0) begin
        write_reg  <= win_rd;
        write_data <= win_data;
      end
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

endmodule
